// File: rtl/m_control_decode.sv
// m_control_decode
// ----------------
// RV32I decode stage between fetch and execute. Accepts one instruction word
// plus its PC over a valid/ready handshake. It decodes the operation class,
// funct3, the alt bit, rd, write-back enable and the sign-extended immediate.
// It also samples both register-file operands. The result is held in one
// output register for execute. Unsupported encodings are flagged as illegal
// but still flow through the handshake. A flush from branch resolution drops
// both the held instruction and any instruction offered in the same cycle.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   flush              discard held and incoming instruction
//   in_valid/in_ready  handshake with fetch; in_instr, in_pc are its payload
//   rs1_addr/rs2_addr  register-file read addresses, combinational from in_instr
//   rs1_data/rs2_data  register-file read data, combinational
//   out_valid/out_ready handshake with execute
//   out_pc, out_class, out_funct3, out_alt, out_rd, out_wb_en,
//   out_imm, out_rs1, out_rs2, out_illegal   decoded instruction fields
module m_control_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_class,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic [4:0]      out_rd,
    output logic            out_wb_en,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic            out_illegal
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] CL_LUI      = 4'd0;
    localparam logic [3:0] CL_AUIPC    = 4'd1;
    localparam logic [3:0] CL_JAL      = 4'd2;
    localparam logic [3:0] CL_JALR     = 4'd3;
    localparam logic [3:0] CL_BRANCH   = 4'd4;
    localparam logic [3:0] CL_LOAD     = 4'd5;
    localparam logic [3:0] CL_STORE    = 4'd6;
    localparam logic [3:0] CL_OP_IMM   = 4'd7;
    localparam logic [3:0] CL_OP       = 4'd8;
    localparam logic [3:0] CL_MISC_MEM = 4'd9;
    localparam logic [3:0] CL_SYSTEM   = 4'd10;
    localparam logic [3:0] CL_ILLEGAL  = 4'd15;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Immediate extraction, one function per RV32I format.
    function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
        return $signed({{20{ins[31]}}, ins[31:20]});
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
        return $signed({{20{ins[31]}}, ins[31:25], ins[11:7]});
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
        return $signed({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
        return $signed({ins[31:12], 12'b0});
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
        return $signed({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
    endfunction

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic               capture;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd;

    logic [3:0]         dec_class;
    logic               dec_bad;
    logic               dec_writes;
    logic               dec_alt;
    logic signed [31:0] dec_imm;
    logic [XLEN-1:0]    dec_rs1;
    logic [XLEN-1:0]    dec_rs2;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rd       = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // x0 always reads as zero, whatever the register file returns.
    assign dec_rs1 = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign dec_rs2 = (rs2_addr == 5'd0) ? '0 : rs2_data;

    assign out_valid = (state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign capture   = in_valid && in_ready && !flush;

    always_comb begin
        dec_class  = CL_ILLEGAL;
        dec_bad    = 1'b0;
        dec_writes = 1'b0;
        dec_alt    = 1'b0;
        dec_imm    = '0;
        unique case (opcode)
            OPC_LUI: begin
                dec_class  = CL_LUI;
                dec_imm    = imm_u(in_instr);
                dec_writes = 1'b1;
            end
            OPC_AUIPC: begin
                dec_class  = CL_AUIPC;
                dec_imm    = imm_u(in_instr);
                dec_writes = 1'b1;
            end
            OPC_JAL: begin
                dec_class  = CL_JAL;
                dec_imm    = imm_j(in_instr);
                dec_writes = 1'b1;
            end
            OPC_JALR: begin
                dec_class  = CL_JALR;
                dec_imm    = imm_i(in_instr);
                dec_writes = 1'b1;
                dec_bad    = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec_class = CL_BRANCH;
                dec_imm   = imm_b(in_instr);
                dec_bad   = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_LOAD: begin
                dec_class  = CL_LOAD;
                dec_imm    = imm_i(in_instr);
                dec_writes = 1'b1;
                dec_bad    = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                dec_class = CL_STORE;
                dec_imm   = imm_s(in_instr);
                dec_bad   = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                dec_class  = CL_OP_IMM;
                dec_imm    = imm_i(in_instr);
                dec_writes = 1'b1;
                // Only the right-shift form carries SRA/SRL in bit 30; for
                // every other OP_IMM that bit is just immediate data.
                dec_alt    = (funct3 == 3'd5) && in_instr[30];
                dec_bad    = ((funct3 == 3'd1) && (funct7 != F7_ZERO)) ||
                             ((funct3 == 3'd5) && (funct7 != F7_ZERO) && (funct7 != F7_ALT));
            end
            OPC_OP: begin
                dec_class  = CL_OP;
                dec_writes = 1'b1;
                dec_alt    = in_instr[30];
                dec_bad    = !((funct7 == F7_ZERO) ||
                               ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
            end
            OPC_MISC_MEM: begin
                dec_class = CL_MISC_MEM;
            end
            OPC_SYSTEM: begin
                dec_class = CL_SYSTEM;
                dec_imm   = imm_i(in_instr);
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
        if (in_instr[1:0] != 2'b11) begin
            dec_bad = 1'b1;
        end
        if (dec_bad) begin
            dec_class  = CL_ILLEGAL;
            dec_writes = 1'b0;
        end
    end

    // Flush beats capture, capture beats drain.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else if (capture) begin
            state_next = ST_FULL;
        end else if ((state == ST_FULL) && out_ready) begin
            state_next = ST_EMPTY;
        end
    end

    // ---- decode -> execute register ----
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= ST_EMPTY;
            out_pc      <= '0;
            out_class   <= '0;
            out_funct3  <= '0;
            out_alt     <= 1'b0;
            out_rd      <= '0;
            out_wb_en   <= 1'b0;
            out_imm     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                out_pc      <= in_pc;
                out_class   <= dec_class;
                out_funct3  <= funct3;
                out_alt     <= dec_alt;
                out_rd      <= rd;
                out_wb_en   <= dec_writes && (rd != 5'd0);
                out_imm     <= dec_imm;
                out_rs1     <= dec_rs1;
                out_rs2     <= dec_rs2;
                out_illegal <= dec_bad;
            end
        end
    end

endmodule

// File: tb/tb_m_control_decode.sv
// Testbench for m_control_decode: a table of known instructions with
// hand-derived results, hand-written stall/flush/reset sequences, then
// randomized traffic scored against a reference decoder.
module tb_m_control_decode;

    logic        clk;
    logic        nrst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;
    logic        out_alt;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic [31:0] out_imm;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    m_control_decode #(.XLEN(32)) dut (
        .clk(clk), .nrst(nrst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_class(out_class), .out_funct3(out_funct3),
        .out_alt(out_alt), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
        logic        alt;
        logic [31:0] o1;
        logic [31:0] o2;
    } vec_t;

    typedef struct {
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wb;
        logic        ill;
        logic        alt;
        logic [31:0] pc;
        logic [31:0] o1;
        logic [31:0] o2;
    } exp_t;

    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".class"}, 32'(out_class), 32'(e.cls));
        chk({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
        chk({tag, ".funct3"}, 32'(out_funct3), 32'(e.f3));
        chk({tag, ".wb_en"}, 32'(out_wb_en), 32'(e.wb));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(e.ill));
        chk({tag, ".pc"}, out_pc, e.pc);
        chk({tag, ".rs1"}, out_rs1, e.o1);
        chk({tag, ".rs2"}, out_rs2, e.o2);
        if (!e.ill) begin
            chk({tag, ".imm"}, out_imm, e.imm);
            chk({tag, ".alt"}, 32'(out_alt), 32'(e.alt));
        end
    endtask

    // Reference decoder built directly from the RV32I format rules using
    // shifts and masks on the whole word.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        int op, f3, f7;
        logic [31:0] sgn;
        logic writes;
        op  = int'(ins & 32'h7F);
        f3  = int'((ins >> 12) & 32'h7);
        f7  = int'((ins >> 25) & 32'h7F);
        sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        e.rd  = 5'((ins >> 7) & 32'h1F);
        e.f3  = 3'(f3);
        e.pc  = pc;
        e.o1  = (((ins >> 15) & 32'h1F) == 0) ? 32'h0 : d1;
        e.o2  = (((ins >> 20) & 32'h1F) == 0) ? 32'h0 : d2;
        e.ill = 1'b0;
        e.alt = 1'b0;
        e.imm = 32'h0;
        e.cls = 4'd15;
        writes = 1'b0;
        case (op)
            'h37: begin e.cls = 4'd0; e.imm = ins & 32'hFFFF_F000; writes = 1'b1; end
            'h17: begin e.cls = 4'd1; e.imm = ins & 32'hFFFF_F000; writes = 1'b1; end
            'h6F: begin
                e.cls = 4'd2; writes = 1'b1;
                e.imm = (sgn << 20) | (((ins >> 12) & 32'hFF) << 12) |
                        (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            end
            'h67: begin
                e.cls = 4'd3; writes = 1'b1; e.ill = (f3 != 0);
                e.imm = (sgn << 12) | (ins >> 20);
            end
            'h63: begin
                e.cls = 4'd4; e.ill = (f3 == 2) || (f3 == 3);
                e.imm = (sgn << 12) | (((ins >> 7) & 32'h1) << 11) |
                        (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
            end
            'h03: begin
                e.cls = 4'd5; writes = 1'b1; e.ill = (f3 inside {3, 6, 7});
                e.imm = (sgn << 12) | (ins >> 20);
            end
            'h23: begin
                e.cls = 4'd6; e.ill = (f3 > 2);
                e.imm = (sgn << 12) | (((ins >> 25) & 32'h7F) << 5) | ((ins >> 7) & 32'h1F);
            end
            'h13: begin
                e.cls = 4'd7; writes = 1'b1;
                e.imm = (sgn << 12) | (ins >> 20);
                if (f3 == 1) e.ill = (f7 != 0);
                if (f3 == 5) begin
                    e.ill = !(f7 == 0 || f7 == 32);
                    e.alt = ins[30];
                end
            end
            'h33: begin
                e.cls = 4'd8; writes = 1'b1; e.alt = ins[30];
                e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            end
            'h0F: e.cls = 4'd9;
            'h73: begin e.cls = 4'd10; e.imm = (sgn << 12) | (ins >> 20); end
            default: e.ill = 1'b1;
        endcase
        if ((ins & 32'h3) != 32'h3) e.ill = 1'b1;
        if (e.ill) begin
            e.cls = 4'd15;
            e.wb  = 1'b0;
        end else begin
            e.wb = writes && (e.rd != 0);
        end
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic v, input logic rdy, input logic fl);
        in_instr  = ins;
        in_pc     = pc;
        rs1_data  = d1;
        rs2_data  = d2;
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        exp_t mexp;
        logic mvalid;
        logic [31:0] r;
        logic [6:0] ops [11];
        int pick;

        //              instr          pc           r1d          r2d    cls   imm            rd  wb ill alt o1       o2
        tbl[0]  = '{32'h0050_0093, 32'h100, 32'hDEAD_BEEF, R2,     4'd7,  32'h5,          5'd1,  1, 0, 0, 32'h0,    R2};
        tbl[1]  = '{32'hFE20_AE23, 32'h104, 32'h1000,      32'hAB, 4'd6,  32'hFFFF_FFFC,  5'd28, 0, 0, 0, 32'h1000, 32'hAB};
        tbl[2]  = '{32'h1234_52B7, 32'h108, R1,            R2,     4'd0,  32'h1234_5000,  5'd5,  1, 0, 0, R1,       R2};
        tbl[3]  = '{32'h40B5_0533, 32'h10C, R1,            R2,     4'd8,  32'h0,          5'd10, 1, 0, 1, R1,       R2};
        tbl[4]  = '{32'h0000_0000, 32'h110, R1,            R2,     4'd15, 32'h0,          5'd0,  0, 1, 0, 32'h0,    32'h0};
        tbl[5]  = '{32'h0000_7003, 32'h114, R1,            R2,     4'd15, 32'h0,          5'd0,  0, 1, 0, 32'h0,    32'h0};
        tbl[6]  = '{32'h0080_00EF, 32'h118, R1,            R2,     4'd2,  32'h8,          5'd1,  1, 0, 0, 32'h0,    R2};
        tbl[7]  = '{32'hFE00_0EE3, 32'h11C, R1,            R2,     4'd4,  32'hFFFF_FFFC,  5'd29, 0, 0, 0, 32'h0,    32'h0};
        tbl[8]  = '{32'h4030_D093, 32'h120, R1,            R2,     4'd7,  32'h403,        5'd1,  1, 0, 1, R1,       R2};
        tbl[9]  = '{32'hFFF0_0093, 32'h124, R1,            R2,     4'd7,  32'hFFFF_FFFF,  5'd1,  1, 0, 0, 32'h0,    R2};
        tbl[10] = '{32'h0000_10E7, 32'h128, R1,            R2,     4'd15, 32'h0,          5'd1,  0, 1, 0, 32'h0,    32'h0};
        tbl[11] = '{32'h4000_1033, 32'h12C, R1,            R2,     4'd15, 32'h0,          5'd0,  0, 1, 0, 32'h0,    32'h0};

        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

        nrst = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) after_edge();
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_pc", out_pc, 32'h0);
        chk("reset.out_class", 32'(out_class), 32'd0);
        chk("reset.out_imm", out_imm, 32'h0);
        @(negedge clk);
        nrst = 1'b1;

        // Back-to-back table vectors with execute always ready.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].instr, tbl[i].pc, tbl[i].r1d, tbl[i].r2d, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("tbl%0d.rs1_addr", i), 32'(rs1_addr), 32'(tbl[i].instr[19:15]));
            chk($sformatf("tbl%0d.rs2_addr", i), 32'(rs2_addr), 32'(tbl[i].instr[24:20]));
            chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'd1);
            after_edge();
            chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'd1);
            e.cls = tbl[i].cls; e.imm = tbl[i].imm; e.rd = tbl[i].rd;
            e.f3 = tbl[i].instr[14:12]; e.wb = tbl[i].wb; e.ill = tbl[i].ill;
            e.alt = tbl[i].alt; e.pc = tbl[i].pc; e.o1 = tbl[i].o1; e.o2 = tbl[i].o2;
            check_out($sformatf("tbl%0d", i), e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        after_edge();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Stall: execute not ready while a second instruction waits.
        @(negedge clk);
        drive(32'h1234_52B7, 32'h200, R1, R2, 1'b1, 1'b1, 1'b0);
        after_edge();
        chk("stall.first_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        drive(32'h40B5_0533, 32'h204, R1, R2, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stall.in_ready", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            after_edge();
            chk($sformatf("stall%0d.out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d.out_pc", c), out_pc, 32'h200);
            chk($sformatf("stall%0d.out_class", c), 32'(out_class), 32'd0);
            chk($sformatf("stall%0d.out_imm", c), out_imm, 32'h1234_5000);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", 32'(in_ready), 32'd1);
        after_edge();
        chk("release.out_valid", 32'(out_valid), 32'd1);
        chk("release.out_pc", out_pc, 32'h204);
        chk("release.out_class", 32'(out_class), 32'd8);
        chk("release.out_alt", 32'(out_alt), 32'd1);

        // Flush while FULL with a new instruction offered.
        @(negedge clk);
        drive(32'h0050_0093, 32'h300, R1, R2, 1'b1, 1'b0, 1'b1);
        after_edge();
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.no_capture_pc", out_pc, 32'h204);
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("flush.stay_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL, between clock edges.
        @(negedge clk);
        drive(32'h0050_0093, 32'h400, R1, R2, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk("areset.pre_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("areset.out_valid", 32'(out_valid), 32'd0);
        chk("areset.out_pc", out_pc, 32'h0);
        chk("areset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        nrst = 1'b1;

        // Randomized traffic against the reference decoder and handshake model.
        mvalid = 1'b0;
        mexp   = ref_decode(32'h0, 32'h0, 32'h0, 32'h0);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r = $urandom;
            pick = int'($urandom_range(0, 11));
            if (pick < 11) r[6:0] = ops[pick];
            if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            drive(r, $urandom, $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            #1;
            chk($sformatf("rnd%0d.in_ready", n), 32'(in_ready), 32'(!mvalid || out_ready));
            if (flush) begin
                mvalid = 1'b0;
            end else if (in_valid && (!mvalid || out_ready)) begin
                mexp   = ref_decode(in_instr, in_pc, rs1_data, rs2_data);
                mvalid = 1'b1;
            end else if (out_ready) begin
                mvalid = 1'b0;
            end
            after_edge();
            chk($sformatf("rnd%0d.out_valid", n), 32'(out_valid), 32'(mvalid));
            if (mvalid) check_out($sformatf("rnd%0d", n), mexp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
